// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared FSM states and constants for the HUB75 scan sequencer
// HUB75_GHOST_BLANK_EN: when defined, BLANK is stretched to 4 cycles to suppress ghosting.
package hub75_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } hub75_state_t;

   // Bit positions inside fb_rd_data = {b1,b0,g1,g0,r1,r0}
   localparam int RD_R0 = 0;
   localparam int RD_R1 = 1;
   localparam int RD_G0 = 2;
   localparam int RD_G1 = 3;
   localparam int RD_B0 = 4;
   localparam int RD_B1 = 5;

   localparam int BLANK_CYCLES_STD   = 1;
   localparam int BLANK_CYCLES_GHOST = 4;

`ifdef HUB75_GHOST_BLANK_EN
   localparam int BLANK_CYCLES = BLANK_CYCLES_GHOST;
`else
   localparam int BLANK_CYCLES = BLANK_CYCLES_STD;
`endif

   localparam logic [1:0] BLANK_LAST = 2'(BLANK_CYCLES - 1);

endpackage

// File: rtl/hub75_scan_sequencer_if.sv
// rtl/hub75_scan_sequencer_if.sv - framebuffer read port and buffer-swap handshake
interface hub75_scan_sequencer_if #(
   parameter int COLUMNS      = 64,
   parameter int ROW_ADDRS    = 16,
   parameter int BITS_PER_RGB = 4
) ();

   logic                            fb_rd_en;
   logic [$clog2(COLUMNS)-1:0]      fb_rd_col;
   logic [$clog2(ROW_ADDRS)-1:0]    fb_rd_row;
   logic [$clog2(BITS_PER_RGB)-1:0] fb_rd_plane;
   logic [5:0]                      fb_rd_data;
   logic                            fb_sel;
   logic                            swap_req;
   logic                            swap_ack;

   modport master (
      output fb_rd_en, fb_rd_col, fb_rd_row, fb_rd_plane, fb_sel, swap_ack,
      input  fb_rd_data, swap_req
   );

   modport slave (
      input  fb_rd_en, fb_rd_col, fb_rd_row, fb_rd_plane, fb_sel, swap_ack,
      output fb_rd_data, swap_req
   );

endinterface

// File: rtl/hub75_bcm_timer.sv
// rtl/hub75_bcm_timer.sv - DISPLAY down-counter; done marks the last OE-low cycle
module hub75_bcm_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == WIDTH'(1));

endmodule

// File: rtl/hub75_scan_sequencer.sv
// rtl/hub75_scan_sequencer.sv - HUB75 panel scan FSM: shift, blank, latch, BCM display
// Optional HUB75_GHOST_BLANK_EN (see hub75_pkg) lengthens BLANK.
module hub75_scan_sequencer
   import hub75_pkg::*;
#(
   parameter int COLUMNS      = 64,
   parameter int ROW_ADDRS    = 16,
   parameter int BITS_PER_RGB = 4,
   parameter int ON_BASE      = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   hub75_scan_sequencer_if.master       fb,
   output logic [1:0]                   hub75_red,
   output logic [1:0]                   hub75_green,
   output logic [1:0]                   hub75_blue,
   output logic [$clog2(ROW_ADDRS)-1:0] hub75_addr,
   output logic                         hub75_clk,
   output logic                         hub75_latch,
   output logic                         hub75_oe
);

   localparam int COL_W   = $clog2(COLUMNS);
   localparam int ROW_W   = $clog2(ROW_ADDRS);
   localparam int PLANE_W = $clog2(BITS_PER_RGB);
   localparam int STEP_W  = $clog2(2 * COLUMNS + 1);
   localparam int ON_W    = $clog2((ON_BASE << (BITS_PER_RGB - 1)) + 1);

   localparam logic [STEP_W-1:0]  SHIFT_LAST = STEP_W'(2 * COLUMNS);
   localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROW_ADDRS - 1);
   localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BITS_PER_RGB - 1);

   hub75_state_t       state, next_state;
   logic [STEP_W-1:0]  step_cnt;
   logic [1:0]         blank_cnt;
   logic [ROW_W-1:0]   row_q;
   logic [PLANE_W-1:0] plane_q;
   logic [ROW_W-1:0]   addr_q;
   logic [5:0]         rgb_q;
   logic               fb_sel_q;
   logic               swap_ack_q;
   logic               stop_q;

   logic shift_odd;
   logic rd_en;
   logic clk_out;
   logic latch_out;
   logic oe_out;
   logic timer_load;
   logic timer_done;
   logic plane_end;
   logic frame_end;

   hub75_bcm_timer #(.WIDTH(ON_W)) u_bcm_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (ON_W'(ON_BASE) << plane_q),
      .done       (timer_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // SHIFT step k: even k < 2*COLUMNS reads column k/2, odd k presents data, even k > 0 clocks it
   always_comb begin
      next_state = state;
      shift_odd  = 1'b0;
      rd_en      = 1'b0;
      clk_out    = 1'b0;
      latch_out  = 1'b0;
      oe_out     = 1'b1;
      timer_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            shift_odd = step_cnt[0];
            rd_en     = !step_cnt[0] && (step_cnt != SHIFT_LAST);
            clk_out   = !step_cnt[0] && (step_cnt != '0);
            if (step_cnt == SHIFT_LAST) next_state = ST_BLANK;
         end
         ST_BLANK: begin
            if (blank_cnt == BLANK_LAST) next_state = ST_LATCH;
         end
         ST_LATCH: begin
            latch_out  = 1'b1;
            timer_load = 1'b1;
            next_state = ST_DISPLAY;
         end
         ST_DISPLAY: begin
            oe_out = 1'b0;
            if (timer_done) next_state = (stop_q || !enable) ? ST_IDLE : ST_SHIFT;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign plane_end = (state == ST_DISPLAY) && timer_done;
   assign frame_end = plane_end && (plane_q == PLANE_LAST) && (row_q == ROW_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_cnt  <= '0;
         blank_cnt <= '0;
         rgb_q     <= '0;
         addr_q    <= '0;
      end else begin
         step_cnt  <= (state == ST_SHIFT && next_state == ST_SHIFT) ? step_cnt + 1'b1 : '0;
         blank_cnt <= (state == ST_BLANK && next_state == ST_BLANK) ? blank_cnt + 1'b1 : '0;
         if (shift_odd) rgb_q <= fb.fb_rd_data;
         // Address moves on entry to BLANK so the change is always covered by OE high
         if (state == ST_SHIFT && next_state == ST_BLANK) addr_q <= row_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q      <= '0;
         plane_q    <= '0;
         stop_q     <= 1'b0;
         fb_sel_q   <= 1'b0;
         swap_ack_q <= 1'b0;
      end else begin
         if (state == ST_IDLE) begin
            stop_q <= 1'b0;
         end else if (!enable) begin
            stop_q <= 1'b1;
         end

         if (plane_end) begin
            if (next_state == ST_IDLE) begin
               row_q   <= '0;
               plane_q <= '0;
            end else if (plane_q == PLANE_LAST) begin
               plane_q <= '0;
               row_q   <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
               plane_q <= plane_q + 1'b1;
            end
         end

         swap_ack_q <= frame_end && fb.swap_req;
         if (frame_end && fb.swap_req) fb_sel_q <= ~fb_sel_q;
      end
   end

   assign fb.fb_rd_en    = rd_en;
   assign fb.fb_rd_col   = COL_W'(step_cnt >> 1);
   assign fb.fb_rd_row   = row_q;
   assign fb.fb_rd_plane = plane_q;
   assign fb.fb_sel      = fb_sel_q;
   assign fb.swap_ack    = swap_ack_q;

   // Read data arrives in the odd step itself; the register holds it through the clock edge
   assign hub75_red   = shift_odd ? {fb.fb_rd_data[RD_R1], fb.fb_rd_data[RD_R0]} : {rgb_q[RD_R1], rgb_q[RD_R0]};
   assign hub75_green = shift_odd ? {fb.fb_rd_data[RD_G1], fb.fb_rd_data[RD_G0]} : {rgb_q[RD_G1], rgb_q[RD_G0]};
   assign hub75_blue  = shift_odd ? {fb.fb_rd_data[RD_B1], fb.fb_rd_data[RD_B0]} : {rgb_q[RD_B1], rgb_q[RD_B0]};

   assign hub75_addr  = addr_q;
   assign hub75_clk   = clk_out;
   assign hub75_latch = latch_out;
   assign hub75_oe    = oe_out;

endmodule

// File: tb/tb_hub75_scan_sequencer.sv
// tb/tb_hub75_scan_sequencer.sv - directed scoreboard bench for hub75_scan_sequencer
module tb_hub75_scan_sequencer;

   localparam int COLUMNS      = 64;
   localparam int ROW_ADDRS    = 16;
   localparam int BITS_PER_RGB = 4;
   localparam int ON_BASE      = 8;
   localparam int COL_W        = $clog2(COLUMNS);
   localparam int ROW_W        = $clog2(ROW_ADDRS);
   localparam int PLANE_W      = $clog2(BITS_PER_RGB);
`ifdef HUB75_GHOST_BLANK_EN
   localparam int BLANK_EXP = 4;
`else
   localparam int BLANK_EXP = 1;
`endif
   localparam logic [5:0] IDLE_DATA = 6'b010101;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [1:0]       hub75_red, hub75_green, hub75_blue;
   logic [ROW_W-1:0] hub75_addr;
   logic             hub75_clk, hub75_latch, hub75_oe;

   hub75_scan_sequencer_if #(.COLUMNS(COLUMNS), .ROW_ADDRS(ROW_ADDRS), .BITS_PER_RGB(BITS_PER_RGB)) fb_if ();

   hub75_scan_sequencer #(
      .COLUMNS(COLUMNS), .ROW_ADDRS(ROW_ADDRS), .BITS_PER_RGB(BITS_PER_RGB), .ON_BASE(ON_BASE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .fb          (fb_if),
      .hub75_red   (hub75_red),
      .hub75_green (hub75_green),
      .hub75_blue  (hub75_blue),
      .hub75_addr  (hub75_addr),
      .hub75_clk   (hub75_clk),
      .hub75_latch (hub75_latch),
      .hub75_oe    (hub75_oe)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int mode = 0;
   int rd_count = 0;
   int last_col = -1, last_row = -1, last_plane = -1;
   int exp_col = 0;
   int edges = 0;
   int since_clk = 0;
   int low_run = 0;
   int planes_done = 0;
   int ack_count = 0;
   bit rd_pend = 0;
   logic [5:0] rd_pend_data;
   logic [ROW_W-1:0] prev_addr = '0;
   logic [5:0] exp_q[$];
   int width_q[$];
   int width_addr_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] fb_pattern(input int m, input int col, input int row, input int plane);
      if (m == 0) return 6'b101010;
      return 6'((col * 7) ^ (row * 3) ^ (plane * 13));
   endfunction

   // Framebuffer model: data for a read appears one cycle after fb_rd_en
   always @(posedge clk) begin
      #1;
      fb_if.fb_rd_data = rd_pend ? rd_pend_data : IDLE_DATA;
      rd_pend = 1'b0;
   end

   // Monitor / scoreboard, sampling at the falling edge
   always @(negedge clk) begin
      if (reset) begin
         rd_pend   = 1'b0;
         low_run   = 0;
         edges     = 0;
         since_clk = 0;
         exp_col   = 0;
         prev_addr = hub75_addr;
      end else begin
         if (fb_if.fb_rd_en) begin
            check("rd_col", 32'(fb_if.fb_rd_col), 32'(exp_col));
            exp_col++;
            last_col   = int'(fb_if.fb_rd_col);
            last_row   = int'(fb_if.fb_rd_row);
            last_plane = int'(fb_if.fb_rd_plane);
            rd_pend_data = fb_pattern(mode, last_col, last_row, last_plane);
            rd_pend = 1'b1;
            exp_q.push_back(rd_pend_data);
            rd_count++;
         end
         if (hub75_clk) begin
            edges++;
            since_clk = 0;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL rgb_queue: observed empty expected pending pixel");
            end
            if (exp_q.size() != 0) check("rgb", 32'({hub75_blue, hub75_green, hub75_red}), 32'(exp_q.pop_front()));
         end else begin
            since_clk++;
         end
         if (hub75_latch) begin
            check("edges_per_latch", edges, COLUMNS);
            check("blank_len", since_clk - 1, BLANK_EXP);
            check("oe_at_latch", 32'(hub75_oe), 1);
            edges   = 0;
            exp_col = 0;
         end
         if (hub75_addr !== prev_addr) check("oe_at_addr_change", 32'(hub75_oe), 1);
         prev_addr = hub75_addr;
         if (!hub75_oe) begin
            low_run++;
         end else if (low_run != 0) begin
            width_q.push_back(low_run);
            width_addr_q.push_back(int'(hub75_addr));
            planes_done++;
            low_run = 0;
         end
         if (fb_if.swap_ack) ack_count++;
      end
   end

   task automatic wait_rd(input int budget, output int n);
      int start;
      start = rd_count;
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk); #1;
         if (rd_count != start) begin n = i; break; end
      end
   endtask

   task automatic wait_widths(input int cnt, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (width_q.size() >= cnt) begin ok = 1; break; end
      end
   endtask

   task automatic wait_ack(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (fb_if.swap_ack === 1'b1) begin ok = 1; break; end
      end
   endtask

   task automatic wait_plane_col(input int plane, input int col, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (fb_if.fb_rd_en === 1'b1 && last_plane == plane && last_col == col) begin ok = 1; break; end
      end
   endtask

   task automatic wait_oe_low(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (hub75_oe === 1'b0) begin ok = 1; break; end
      end
   endtask

   initial begin
      int  n, rc, w;
      bit  ok;
      reset = 1'b1;
      enable = 1'b0;
      fb_if.swap_req = 1'b0;
      fb_if.fb_rd_data = IDLE_DATA;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_oe", 32'(hub75_oe), 1);
      check("rst_clk", 32'(hub75_clk), 0);
      check("rst_latch", 32'(hub75_latch), 0);
      check("rst_addr", 32'(hub75_addr), 0);
      check("rst_rgb", 32'({hub75_blue, hub75_green, hub75_red}), 0);
      check("rst_fb_sel", 32'(fb_if.fb_sel), 0);
      check("rst_swap_ack", 32'(fb_if.swap_ack), 0);
      check("rst_rd_en", 32'(fb_if.fb_rd_en), 0);
      reset = 1'b0;
      @(negedge clk); #1;

      // First read follows enable by one cycle, row 0 plane 0 column 0
      enable = 1'b1;
      wait_rd(10, n);
      check("first_rd_latency", n, 1);
      check("first_rd_row", last_row, 0);
      check("first_rd_plane", last_plane, 0);
      check("first_rd_col", last_col, 0);

      // Row 0 BCM widths 8,16,32,64 with addr 0, constant 101010 pixels
      wait_widths(4, 3000, ok);
      check("row0_widths_timeout", 32'(ok), 1);
      for (int i = 0; i < 4 && width_q.size() > 0; i++) begin
         w = width_q.pop_front();
         check("row0_oe_width", w, ON_BASE << i);
         check("row0_addr", width_addr_q.pop_front(), 0);
      end
      mode = 1;

      // Swap requested mid-frame completes only at frame end
      repeat (2000) @(negedge clk);
      #1;
      fb_if.swap_req = 1'b1;
      wait_ack(12000, ok);
      check("swap_ack_timeout", 32'(ok), 1);
      check("swap_fb_sel", 32'(fb_if.fb_sel), 1);
      check("swap_planes_done", planes_done, ROW_ADDRS * BITS_PER_RGB);
      check("swap_addr_last_row", 32'(hub75_addr), ROW_ADDRS - 1);
      check("swap_next_rd_row", last_row, 0);
      check("swap_next_rd_plane", last_plane, 0);
      fb_if.swap_req = 1'b0;
      @(negedge clk); #1;
      check("swap_ack_one_cycle", 32'(fb_if.swap_ack), 0);
      check("swap_fb_sel_hold", 32'(fb_if.fb_sel), 1);

      // Enable dropped mid-SHIFT of plane 2: plane finishes, 32-cycle display, then idle
      wait_plane_col(2, 10, 3000, ok);
      check("plane2_timeout", 32'(ok), 1);
      enable = 1'b0;
      rc = rd_count;
      width_q.delete();
      width_addr_q.delete();
      wait_widths(1, 500, ok);
      check("stop_width_timeout", 32'(ok), 1);
      if (width_q.size() > 0) check("stop_oe_width", width_q.pop_front(), ON_BASE << 2);
      check("stop_remaining_reads", rd_count - rc, COLUMNS - 11);
      check("stop_oe_high", 32'(hub75_oe), 1);
      rc = rd_count;
      repeat (30) @(negedge clk);
      #1;
      check("idle_no_reads", rd_count - rc, 0);
      check("idle_no_display", width_q.size(), 0);
      check("idle_oe", 32'(hub75_oe), 1);

      // Restart begins at row 0 plane 0
      enable = 1'b1;
      wait_rd(10, n);
      check("restart_rd_latency", n, 1);
      check("restart_rd_row", last_row, 0);
      check("restart_rd_plane", last_plane, 0);
      check("restart_rd_col", last_col, 0);

      // Reset asserted mid-DISPLAY takes effect at once
      wait_oe_low(1000, ok);
      check("display_timeout", 32'(ok), 1);
      repeat (3) @(negedge clk);
      #1;
      check("all_pixels_clocked", exp_q.size(), 0);
      reset = 1'b1;
      #1;
      check("rst_async_oe", 32'(hub75_oe), 1);
      @(negedge clk); #1;
      check("rst_mid_oe", 32'(hub75_oe), 1);
      check("rst_mid_fb_sel", 32'(fb_if.fb_sel), 0);
      check("rst_mid_latch", 32'(hub75_latch), 0);
      check("rst_mid_addr", 32'(hub75_addr), 0);
      enable = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("swap_ack_total", ack_count, 1);
      check("post_rst_idle_oe", 32'(hub75_oe), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
